// File: rtl/color_shadow_bank.sv
// Double-buffered RGB colour registers: writes land in a shadow bank and are copied to the
// active bank at frame_end, so the DAC outputs never change mid-frame.
module color_shadow_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       data_in_valid,
  input  logic [1:0] channel,
  input  logic       frame_end,
  input  logic       blank,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       pending,
  output logic       commit,
  output logic [7:0] commit_count
);

  typedef enum logic [0:0] {StIdle, StDirty} state_e;

  state_e     state_q, state_d;
  logic [3:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
  logic [3:0] act_r_q, act_r_d, act_g_q, act_g_d, act_b_q, act_b_d;
  logic [3:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic       commit_q, commit_d;
  logic [7:0] count_q, count_d;
  logic       do_commit;

  assign do_commit = frame_end && (state_q == StDirty);

  // Shadow writes
  always_comb begin
    sh_r_d = sh_r_q;
    sh_g_d = sh_g_q;
    sh_b_d = sh_b_q;
    if (data_in_valid) begin
      unique case (channel)
        2'd0: sh_r_d = data_in;
        2'd1: sh_g_d = data_in;
        2'd2: sh_b_d = data_in;
        2'd3: begin
          sh_r_d = data_in;
          sh_g_d = data_in;
          sh_b_d = data_in;
        end
        default: ;
      endcase
    end
  end

  // Pending FSM; a write on the commit edge keeps the bank dirty for the next frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (data_in_valid) state_d = StDirty;
      StDirty: if (frame_end && !data_in_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    act_r_d  = act_r_q;
    act_g_d  = act_g_q;
    act_b_d  = act_b_q;
    count_d  = count_q;
    commit_d = do_commit;
    if (do_commit) begin
      act_r_d = sh_r_q;
      act_g_d = sh_g_q;
      act_b_d = sh_b_q;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
  end

  always_comb begin
    red_d   = blank ? 4'h0 : act_r_q;
    green_d = blank ? 4'h0 : act_g_q;
    blue_d  = blank ? 4'h0 : act_b_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      sh_r_q   <= 4'h0;
      sh_g_q   <= 4'h0;
      sh_b_q   <= 4'h0;
      act_r_q  <= 4'h0;
      act_g_q  <= 4'h0;
      act_b_q  <= 4'h0;
      red_q    <= 4'h0;
      green_q  <= 4'h0;
      blue_q   <= 4'h0;
      commit_q <= 1'b0;
      count_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      sh_r_q   <= sh_r_d;
      sh_g_q   <= sh_g_d;
      sh_b_q   <= sh_b_d;
      act_r_q  <= act_r_d;
      act_g_q  <= act_g_d;
      act_b_q  <= act_b_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      commit_q <= commit_d;
      count_q  <= count_d;
    end
  end

  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign pending      = (state_q == StDirty);
  assign commit       = commit_q;
  assign commit_count = count_q;

endmodule
